// File: rtl/mux_arb_n1_if.sv
// Handshake bundle for mux_arb_n1: NUM_IN valid/ready input channels and one
// registered valid/ready output channel with source index and select error.
interface mux_arb_n1_if #(
  parameter int N      = 16,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*N-1:0] in_data;
  logic [NUM_IN-1:0]   in_valid;
  logic [NUM_IN-1:0]   in_ready;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic [N-1:0]        out_data;
  logic [SEL_W-1:0]    out_src;
  logic                out_valid;
  logic                out_ready;
  logic                sel_err;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_src, out_valid, sel_err
  );
endinterface

// File: rtl/mux_arb_n1.sv
// Registered NUM_IN:1 multiplexer with fixed-select or round-robin arbitration
// and a one-stage output register that refills on the cycle it drains.
module mux_arb_n1 #(
  parameter int N      = 16,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic         clk,
  input logic         rst_n,
  mux_arb_n1_if.slave bus
);
  localparam int PAD_W = 2 ** SEL_W;

  logic              load_en_s;
  logic              sel_ok_s;
  logic [PAD_W-1:0]  valid_pad_s;
  logic              grant_vld_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic [N-1:0]      grant_data_s;
  logic              transfer_s;
  logic [NUM_IN-1:0] in_ready_s;

  logic [N-1:0]      out_data_r;
  logic [SEL_W-1:0]  out_src_r;
  logic              out_valid_r;
  logic              sel_err_r;
  logic [SEL_W-1:0]  rr_ptr_r;

  assign load_en_s   = !out_valid_r || bus.out_ready;
  assign sel_ok_s    = (int'(bus.sel) < NUM_IN);
  // Padding lets an out-of-range sel index the valid vector safely.
  assign valid_pad_s = PAD_W'(bus.in_valid);
  assign transfer_s  = grant_vld_s && load_en_s;

  // Grant selection: fixed select, or first valid channel at/after rr_ptr.
  always_comb begin
    int cand;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand        = 0;
    if (bus.mode == 1'b0) begin
      grant_vld_s = sel_ok_s && valid_pad_s[bus.sel];
      grant_idx_s = bus.sel;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        cand        = ((int'(rr_ptr_r) + k) >= NUM_IN) ? (int'(rr_ptr_r) + k - NUM_IN)
                                                       : (int'(rr_ptr_r) + k);
        grant_idx_s = (!grant_vld_s && bus.in_valid[cand]) ? SEL_W'(cand) : grant_idx_s;
        grant_vld_s = grant_vld_s || bus.in_valid[cand];
      end
    end
  end

  // Data mux and per-channel ready decode for the granted channel.
  always_comb begin
    grant_data_s = '0;
    in_ready_s   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant_data_s  = (grant_idx_s == SEL_W'(i)) ? bus.in_data[i*N +: N] : grant_data_s;
      in_ready_s[i] = transfer_s && (grant_idx_s == SEL_W'(i));
    end
  end

  // Output register: load on transfer, empty when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (transfer_s) begin
      out_data_r  <= grant_data_s;
      out_src_r   <= grant_idx_s;
      out_valid_r <= 1'b1;
    end else if (load_en_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer moves past the channel just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (transfer_s && bus.mode) begin
      rr_ptr_r <= (grant_idx_s == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx_s + SEL_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Select-range error flag, independent of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= !bus.mode && !sel_ok_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sel_err   = sel_err_r;
endmodule

// File: tb/tb_mux_arb_n1.sv
// Randomized and directed bench for mux_arb_n1 with a queue scoreboard fed by
// a behavioural arbitration model and drained by an output monitor.
module tb_mux_arb_n1;
  localparam int N      = 16;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  typedef struct packed {
    logic [N-1:0]     d;
    logic [SEL_W-1:0] s;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   checking = 1'b0;

  word_t exp_q[$];
  int    src_log[$];
  logic  m_full    = 1'b0;
  logic  m_sel_err = 1'b0;
  int    m_rr      = 0;

  mux_arb_n1_if #(.N(N), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  mux_arb_n1 #(.N(N), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference grant: channel index or -1, from the arbitration rules.
  function automatic int model_grant();
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) >= NUM_IN) return -1;
      return bus.in_valid[bus.sel] ? int'(bus.sel) : -1;
    end
    for (int k = 0; k < NUM_IN; k++)
      if (bus.in_valid[(m_rr + k) % NUM_IN]) return (m_rr + k) % NUM_IN;
    return -1;
  endfunction

  function automatic logic model_load();
    return !m_full || bus.out_ready;
  endfunction

  // Reference model state update; pushes each accepted word to the scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_full    <= 1'b0;
      m_rr      <= 0;
      m_sel_err <= 1'b0;
    end else begin
      m_sel_err <= (bus.mode == 1'b0) && (int'(bus.sel) >= NUM_IN);
      if (model_grant() >= 0 && model_load()) begin
        exp_q.push_back({bus.in_data[model_grant()*N +: N], SEL_W'(model_grant())});
        m_full <= 1'b1;
        if (bus.mode) m_rr <= (model_grant() + 1) % NUM_IN;
      end else if (model_load()) begin
        m_full <= 1'b0;
      end
    end
  end

  task automatic monitor_step();
    int    g;
    word_t w;
    g = model_grant();
    chk("in_ready", 32'(bus.in_ready),
        (g >= 0 && model_load()) ? (32'd1 << g) : 32'd0);
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("sel_err", 32'(bus.sel_err), 32'(m_sel_err));
    if (bus.out_valid && bus.out_ready) begin
      src_log.push_back(int'(bus.out_src));
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", 32'(bus.out_data), 32'(w.d));
        chk("sb_src", 32'(bus.out_src), 32'(w.s));
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) if (checking) monitor_step();

  task automatic cyc(input logic [NUM_IN-1:0] v, input logic m, input logic [SEL_W-1:0] s,
                     input logic r);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.sel       = s;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*N +: N] = N'($urandom);
  endtask

  initial begin
    logic [N-1:0]     hold_d;
    logic [SEL_W-1:0] hold_s;
    int exp_a[7];
    int exp_b[4];
    exp_a = '{0, 1, 2, 3, 4, 0, 1};
    exp_b = '{1, 4, 1, 4};
    bus.in_data = '0; bus.in_valid = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
    do_reset();
    checking = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);

    rand_data();
    bus.in_data[2*N +: N] = 16'hBEEF;
    bus.in_data[4*N +: N] = 16'h4444;
    cyc(5'b00100, 1'b0, 3'd2, 1'b1);
    chk("fixed_data", 32'(bus.out_data), 32'h0000BEEF);
    chk("fixed_src", 32'(bus.out_src), 32'd2);
    cyc(5'b11111, 1'b0, 3'd5, 1'b1);
    chk("badsel_valid", 32'(bus.out_valid), 32'd0);
    chk("badsel_err", 32'(bus.sel_err), 32'd1);
    cyc(5'b11111, 1'b0, 3'd4, 1'b1);
    chk("sel4_data", 32'(bus.out_data), 32'h00004444);
    chk("sel4_err", 32'(bus.sel_err), 32'd0);

    cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    hold_d = bus.out_data;
    hold_s = bus.out_src;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cyc(5'b11111, 1'b1, 3'd0, 1'b0);
      chk("bp_data", 32'(bus.out_data), 32'(hold_d));
      chk("bp_src", 32'(bus.out_src), 32'(hold_s));
    end
    cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_release_src", 32'(bus.out_src), 32'd1);

    do_reset();
    src_log.delete();
    for (int i = 0; i < 7; i++) cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    cyc(5'b00000, 1'b1, 3'd0, 1'b1);
    chk("rr_all_count", 32'(src_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < src_log.size(); i++) chk("rr_all_seq", 32'(src_log[i]), 32'(exp_a[i]));

    do_reset();
    src_log.delete();
    for (int i = 0; i < 4; i++) cyc(5'b10010, 1'b1, 3'd0, 1'b1);
    cyc(5'b00000, 1'b1, 3'd0, 1'b1);
    chk("rr_sparse_count", 32'(src_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++) chk("rr_sparse_seq", 32'(src_log[i]), 32'(exp_b[i]));

    do_reset();
    for (int i = 0; i < 4; i++) cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    chk("sw_rr_src3", 32'(bus.out_src), 32'd3);
    cyc(5'b11111, 1'b0, 3'd0, 1'b1);
    chk("sw_fixed_src0a", 32'(bus.out_src), 32'd0);
    cyc(5'b11111, 1'b0, 3'd0, 1'b1);
    chk("sw_fixed_src0b", 32'(bus.out_src), 32'd0);
    cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    chk("sw_rr_resume", 32'(bus.out_src), 32'd4);

    cyc(5'b11111, 1'b1, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_data", 32'(bus.out_data), 32'd0);
    bus.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(5'b11111, 1'b1, 3'd0, 1'b1);
    chk("post_rst_src", 32'(bus.out_src), 32'd0);

    do_reset();
    for (int i = 0; i < 500; i++) begin
      rand_data();
      cyc(NUM_IN'($urandom), 1'($urandom), SEL_W'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0));
    end
    cyc(5'b00000, 1'b1, 3'd0, 1'b1);
    cyc(5'b00000, 1'b1, 3'd0, 1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
